alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response port.
// The arbiter uses the slave view; the environment (requesters, ALU, consumer) uses the master view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC (capture ALU) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic             prio_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [2:0]       op_ctrl_reg;
  logic             op_id_reg;
  logic [WIDTH-1:0] rsp_result_reg;
  logic [3:0]       rsp_flags_reg;
  logic             rsp_id_reg;
  logic             rsp_valid_reg;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a  [2];
  logic [WIDTH-1:0] req_b  [2];
  logic [2:0]       req_op [2];
  logic             grant_id;
  logic             accept;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;
  assign req_op[0] = bus.req0_op;
  assign req_op[1] = bus.req1_op;

  // A lone requester wins outright; under contention the priority pointer decides.
  assign grant_id = (&req_valid) ? prio_reg : req_valid[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant_id == 1'(gi));
    end
  endgenerate

  assign accept         = |req_ready;
  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  // The ALU only ever sees captured operands, so requesters may change inputs after the handshake.
  assign bus.alu_a      = op_a_reg;
  assign bus.alu_b      = op_b_reg;
  assign bus.alu_ctrl   = op_ctrl_reg;

  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_flags  = rsp_flags_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      prio_reg       <= 1'b0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_ctrl_reg    <= '0;
      op_id_reg      <= 1'b0;
      rsp_result_reg <= '0;
      rsp_flags_reg  <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg    <= req_a[grant_id];
            op_b_reg    <= req_b[grant_id];
            op_ctrl_reg <= req_op[grant_id];
            op_id_reg   <= grant_id;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_reg <= bus.alu_result;
          rsp_flags_reg  <= bus.alu_flags;
          rsp_id_reg     <= op_id_reg;
          rsp_valid_reg  <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          // Handing priority to the requester not served gives strict alternation under contention.
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            prio_reg      <= ~op_id_reg;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
